// File: rtl/game_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : game_sequencer
//  Description : Frame-synchronous controller for the raccoon road-crossing
//                game: player moves, car scrolling, collisions, goals, lives.
//                Optional macro PAUSE_EN adds a start-button pause toggle.
//  Revision    : 1.0 - initial release
// ============================================================================
module game_sequencer #(
    parameter int SCREEN_W    = 640,
    parameter int SCREEN_H    = 480,
    parameter int GRID        = 32,
    parameter int PLAYER_W    = 32,
    parameter int PLAYER_H    = 32,
    parameter int CAR_W       = 64,
    parameter int CAR_H       = 32,
    parameter int CAR_SPEED   = 2,
    parameter int START_LIVES = 3,
    parameter int HIT_FRAMES  = 60
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_start,
    output logic [9:0] raccoonX,
    output logic [9:0] raccoonY,
    output logic [9:0] carX_1,
    output logic [9:0] carY_1,
    output logic [9:0] carX_2,
    output logic [9:0] carY_2,
    output logic [9:0] carX_3,
    output logic [9:0] carY_3,
    output logic [2:0] lives,
    output logic [7:0] score,
    output logic       game_over,
    output logic       invuln
);

    localparam logic [9:0]  c_START_X = 10'(GRID * 9);
    localparam logic [9:0]  c_START_Y = 10'(SCREEN_H - 2 * GRID);
    localparam logic [10:0] c_MAX_X   = 11'(SCREEN_W - PLAYER_W);
    localparam logic [10:0] c_MAX_Y   = 11'(SCREEN_H - 2 * GRID);
    localparam logic [10:0] c_GRID    = 11'(GRID);
    localparam logic [10:0] c_SCR_W   = 11'(SCREEN_W);
    localparam logic [10:0] c_SPEED   = 11'(CAR_SPEED);
    localparam logic [9:0]  c_CAR1_Y  = 10'(GRID * 3);
    localparam logic [9:0]  c_CAR2_Y  = 10'(GRID * 6);
    localparam logic [9:0]  c_CAR3_Y  = 10'(GRID * 9);
    localparam logic [9:0]  c_CAR1_X0 = 10'd0;
    localparam logic [9:0]  c_CAR2_X0 = 10'd320;
    localparam logic [9:0]  c_CAR3_X0 = 10'd160;
    localparam logic [2:0]  c_LIVES   = 3'(START_LIVES);
    localparam int          c_HW      = $clog2(HIT_FRAMES + 1);
    localparam logic [c_HW-1:0] c_HIT = c_HW'(HIT_FRAMES);
    localparam logic [c_HW-1:0] c_ONE = c_HW'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PLAY = 2'd1,
        S_HIT  = 2'd2,
        S_OVER = 2'd3
    } state_t;

    state_t          r_state, w_state_n;
    logic [4:0]      r_btn_q, w_btn, w_rise;
    logic [3:0]      r_pend, w_pend, w_pend_n;
    logic            r_check, w_step, w_hit, w_mv_ok, w_paused;
    logic [9:0]      r_rx, r_ry, r_cx1, r_cx2, r_cx3;
    logic [9:0]      w_rx_n, w_ry_n, w_cx1_n, w_cx2_n, w_cx3_n;
    logic [10:0]     w_mv_x, w_mv_y, w_c1, w_c2, w_c3;
    logic [2:0]      r_lives, w_lives_n;
    logic [7:0]      r_score, w_score_n;
    logic [c_HW-1:0] r_cnt, w_cnt_n;

    function automatic logic f_overlap(input logic [9:0] px, input logic [9:0] py,
                                       input logic [9:0] cx, input logic [9:0] cy);
        return ({1'b0, px} < {1'b0, cx} + 11'(CAR_W))
            && ({1'b0, px} + 11'(PLAYER_W) > {1'b0, cx})
            && ({1'b0, py} < {1'b0, cy} + 11'(CAR_H))
            && ({1'b0, py} + 11'(PLAYER_H) > {1'b0, cy});
    endfunction

    assign w_btn  = {btn_start, btn_up, btn_down, btn_left, btn_right};
    assign w_rise = w_btn & ~r_btn_q;
    assign w_pend = r_pend | w_rise[3:0];
    assign w_step = frame_tick && (r_state == S_PLAY || r_state == S_HIT) && !w_paused;
    assign w_hit  = f_overlap(r_rx, r_ry, r_cx1, c_CAR1_Y)
                  | f_overlap(r_rx, r_ry, r_cx2, c_CAR2_Y)
                  | f_overlap(r_rx, r_ry, r_cx3, c_CAR3_Y);

    // Highest-priority pending move; an off-field result wraps above the limit and is dropped
    always_comb begin
        w_mv_x = {1'b0, r_rx};
        w_mv_y = {1'b0, r_ry};
        if (w_pend[3])      w_mv_y = {1'b0, r_ry} - c_GRID;
        else if (w_pend[2]) w_mv_y = {1'b0, r_ry} + c_GRID;
        else if (w_pend[1]) w_mv_x = {1'b0, r_rx} - c_GRID;
        else if (w_pend[0]) w_mv_x = {1'b0, r_rx} + c_GRID;
        w_mv_ok = (w_mv_x <= c_MAX_X) && (w_mv_y <= c_MAX_Y);
    end

    always_comb begin
        w_c1 = {1'b0, r_cx1} + c_SPEED;
        w_c3 = {1'b0, r_cx3} + c_SPEED;
        if (w_c1 >= c_SCR_W) w_c1 = w_c1 - c_SCR_W;
        if (w_c3 >= c_SCR_W) w_c3 = w_c3 - c_SCR_W;
        if ({1'b0, r_cx2} < c_SPEED) w_c2 = {1'b0, r_cx2} + c_SCR_W - c_SPEED;
        else                         w_c2 = {1'b0, r_cx2} - c_SPEED;
    end

    always_comb begin
        w_state_n = r_state;
        w_pend_n  = frame_tick ? 4'b0000 : w_pend;
        w_rx_n    = r_rx;
        w_ry_n    = r_ry;
        w_cx1_n   = r_cx1;
        w_cx2_n   = r_cx2;
        w_cx3_n   = r_cx3;
        w_lives_n = r_lives;
        w_score_n = r_score;
        w_cnt_n   = r_cnt;

        if (w_step) begin
            if (w_mv_ok) begin
                w_rx_n = w_mv_x[9:0];
                w_ry_n = w_mv_y[9:0];
            end
            w_cx1_n = w_c1[9:0];
            w_cx2_n = w_c2[9:0];
            w_cx3_n = w_c3[9:0];
        end

        // Outcome of the frame's moves is judged one cycle after frame_tick
        if (r_check) begin
            if (r_state == S_PLAY) begin
                if (w_hit) begin
                    if (r_lives <= 3'd1) begin
                        w_lives_n = 3'd0;
                        w_state_n = S_OVER;
                    end else begin
                        w_lives_n = r_lives - 3'd1;
                        w_state_n = S_HIT;
                        w_cnt_n   = c_HIT;
                        w_rx_n    = c_START_X;
                        w_ry_n    = c_START_Y;
                    end
                end else if (r_ry == 10'd0) begin
                    if (r_score != 8'hFF) w_score_n = r_score + 8'd1;
                    w_rx_n = c_START_X;
                    w_ry_n = c_START_Y;
                end
            end else if (r_state == S_HIT) begin
                if (r_cnt <= c_ONE) begin
                    w_cnt_n   = '0;
                    w_state_n = S_PLAY;
                end else begin
                    w_cnt_n = r_cnt - c_ONE;
                end
            end
        end

        case (r_state)
            S_IDLE: if (w_rise[4]) w_state_n = S_PLAY;
            S_OVER: begin
                if (w_rise[4]) begin
                    w_state_n = S_PLAY;
                    w_pend_n  = 4'b0000;
                    w_rx_n    = c_START_X;
                    w_ry_n    = c_START_Y;
                    w_cx1_n   = c_CAR1_X0;
                    w_cx2_n   = c_CAR2_X0;
                    w_cx3_n   = c_CAR3_X0;
                    w_lives_n = c_LIVES;
                    w_score_n = 8'd0;
                    w_cnt_n   = '0;
                end
            end
            default: ;
        endcase
    end

`ifdef PAUSE_EN
    logic r_paused, w_paused_n;

    always_comb begin
        w_paused_n = r_paused;
        if ((r_state == S_PLAY || r_state == S_HIT) && w_rise[4]) w_paused_n = ~r_paused;
        if (w_state_n == S_OVER) w_paused_n = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) r_paused <= 1'b0;
        else       r_paused <= w_paused_n;
    end

    assign w_paused = r_paused;
`else
    assign w_paused = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_btn_q <= 5'b00000;
            r_pend  <= 4'b0000;
            r_check <= 1'b0;
            r_rx    <= c_START_X;
            r_ry    <= c_START_Y;
            r_cx1   <= c_CAR1_X0;
            r_cx2   <= c_CAR2_X0;
            r_cx3   <= c_CAR3_X0;
            r_lives <= c_LIVES;
            r_score <= 8'd0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_n;
            r_btn_q <= w_btn;
            r_pend  <= w_pend_n;
            r_check <= w_step;
            r_rx    <= w_rx_n;
            r_ry    <= w_ry_n;
            r_cx1   <= w_cx1_n;
            r_cx2   <= w_cx2_n;
            r_cx3   <= w_cx3_n;
            r_lives <= w_lives_n;
            r_score <= w_score_n;
            r_cnt   <= w_cnt_n;
        end
    end

    assign raccoonX  = r_rx;
    assign raccoonY  = r_ry;
    assign carX_1    = r_cx1;
    assign carY_1    = c_CAR1_Y;
    assign carX_2    = r_cx2;
    assign carY_2    = c_CAR2_Y;
    assign carX_3    = r_cx3;
    assign carY_3    = c_CAR3_Y;
    assign lives     = r_lives;
    assign score     = r_score;
    assign game_over = (r_state == S_OVER);
    assign invuln    = (r_state == S_HIT);

endmodule
`default_nettype wire

// File: tb/tb_game_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_game_sequencer
//  Description : Self-checking bench for game_sequencer against a per-frame
//                game model. Define PAUSE_EN to also exercise the pause toggle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_game_sequencer;

    localparam int SCREEN_W = 640, SCREEN_H = 480, GRID = 32;
    localparam int PLAYER_W = 32, PLAYER_H = 32, CAR_W = 64, CAR_H = 32;
    localparam int CAR_SPEED = 2, START_LIVES = 3, HIT_FRAMES = 60;
    localparam int START_X = 288, START_Y = 416;
    localparam int M_IDLE = 0, M_PLAY = 1, M_HIT = 2, M_OVER = 3;
    localparam logic [92:0] RESET_VEC = {10'd288, 10'd416, 10'd0, 10'd96, 10'd320, 10'd192,
                                         10'd160, 10'd288, 3'd3, 8'd0, 1'b0, 1'b0};

    logic clk = 1'b0, reset = 1'b1, frame_tick = 1'b0;
    logic btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0, btn_start = 1'b0;
    logic [9:0] raccoonX, raccoonY, carX_1, carY_1, carX_2, carY_2, carX_3, carY_3;
    logic [2:0] lives;
    logic [7:0] score;
    logic       game_over, invuln;
    logic [92:0] dut_vec;

    int checks = 0, failures = 0;

    // Game model state
    int m_state, m_rx, m_ry, m_lives, m_score, m_cnt;
    int m_cx[3];
    int m_cy[3];
    bit m_paused;

    game_sequencer dut (
        .clk(clk), .reset(reset), .frame_tick(frame_tick),
        .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left),
        .btn_right(btn_right), .btn_start(btn_start),
        .raccoonX(raccoonX), .raccoonY(raccoonY),
        .carX_1(carX_1), .carY_1(carY_1), .carX_2(carX_2), .carY_2(carY_2),
        .carX_3(carX_3), .carY_3(carY_3),
        .lives(lives), .score(score), .game_over(game_over), .invuln(invuln)
    );

    always #5 clk = ~clk;

    assign dut_vec = {raccoonX, raccoonY, carX_1, carY_1, carX_2, carY_2, carX_3, carY_3,
                      lives, score, game_over, invuln};

    function automatic logic [92:0] m_vec();
        return {10'(m_rx), 10'(m_ry), 10'(m_cx[0]), 10'(m_cy[0]), 10'(m_cx[1]), 10'(m_cy[1]),
                10'(m_cx[2]), 10'(m_cy[2]), 3'(m_lives), 8'(m_score),
                m_state == M_OVER, m_state == M_HIT};
    endfunction

    function automatic bit m_overlap(input int i);
        return m_rx < m_cx[i] + CAR_W && m_rx + PLAYER_W > m_cx[i] &&
               m_ry < m_cy[i] + CAR_H && m_ry + PLAYER_H > m_cy[i];
    endfunction

    task automatic m_reset();
        m_state = M_IDLE; m_rx = START_X; m_ry = START_Y;
        m_cx[0] = 0;   m_cx[1] = 320; m_cx[2] = 160;
        m_cy[0] = 96;  m_cy[1] = 192; m_cy[2] = 288;
        m_lives = START_LIVES; m_score = 0; m_cnt = 0; m_paused = 0;
    endtask

    task automatic m_start();
        if (m_state == M_IDLE) m_state = M_PLAY;
        else if (m_state == M_OVER) begin
            m_reset();
            m_state = M_PLAY;
        end
`ifdef PAUSE_EN
        else m_paused = !m_paused;
`endif
    endtask

    task automatic m_frame(input bit [3:0] d);
        int nx, ny;
        bit hit;
        if (!(m_state == M_PLAY || m_state == M_HIT) || m_paused) return;
        nx = m_rx; ny = m_ry;
        if (d[3]) ny -= GRID;
        else if (d[2]) ny += GRID;
        else if (d[1]) nx -= GRID;
        else if (d[0]) nx += GRID;
        if (nx >= 0 && nx <= SCREEN_W - PLAYER_W && ny >= 0 && ny <= SCREEN_H - 2 * GRID) begin
            m_rx = nx; m_ry = ny;
        end
        m_cx[0] = (m_cx[0] + CAR_SPEED) % SCREEN_W;
        m_cx[1] = (m_cx[1] - CAR_SPEED + SCREEN_W) % SCREEN_W;
        m_cx[2] = (m_cx[2] + CAR_SPEED) % SCREEN_W;
        hit = 0;
        for (int i = 0; i < 3; i++) hit |= m_overlap(i);
        if (m_state == M_PLAY) begin
            if (hit) begin
                m_lives--;
                if (m_lives == 0) begin
                    m_state = M_OVER; m_paused = 0;
                end else begin
                    m_state = M_HIT; m_cnt = HIT_FRAMES; m_rx = START_X; m_ry = START_Y;
                end
            end else if (m_ry == 0) begin
                if (m_score < 255) m_score++;
                m_rx = START_X; m_ry = START_Y;
            end
        end else begin
            m_cnt--;
            if (m_cnt == 0) m_state = M_PLAY;
        end
    endtask

    task automatic pulse(input bit [4:0] b);
        @(negedge clk) {btn_start, btn_up, btn_down, btn_left, btn_right} = b;
        @(negedge clk) {btn_start, btn_up, btn_down, btn_left, btn_right} = 5'b0;
        @(negedge clk);
    endtask

    task automatic tick();
        @(negedge clk) frame_tick = 1'b1;
        @(negedge clk) frame_tick = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic do_frame(input bit [3:0] d);
        if (d != 4'b0) pulse({1'b0, d});
        tick();
        m_frame(d);
    endtask

    task automatic do_start();
        pulse(5'b10000);
        m_start();
    endtask

    task automatic do_reset();
        @(negedge clk) reset = 1'b1;
        @(negedge clk);
        @(negedge clk) reset = 1'b0;
        m_reset();
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (dut_vec !== RESET_VEC) begin
            failures++; $display("FAIL reset_values got=%h exp=%h", dut_vec, RESET_VEC);
        end
        do_frame(4'b1000);
        checks++;
        if (dut_vec !== RESET_VEC) begin
            failures++; $display("FAIL idle_frozen got=%h exp=%h", dut_vec, RESET_VEC);
        end
    endtask

    task automatic test_start();
        do_start();
        do_frame(4'b0000);
        checks++;
        if ({raccoonX, raccoonY, carX_1, carX_2, carX_3, lives, invuln} !==
            {10'd288, 10'd416, 10'd2, 10'd318, 10'd162, 3'd3, 1'b0}) begin
            failures++;
            $display("FAIL first_frame got=%h exp=%h",
                     {raccoonX, raccoonY, carX_1, carX_2, carX_3, lives},
                     {10'd288, 10'd416, 10'd2, 10'd318, 10'd162, 3'd3});
        end
    endtask

    task automatic test_wrap();
        for (int f = 2; f <= 319; f++) begin
            do_frame(4'b0000);
            checks++;
            if (dut_vec !== m_vec()) begin
                failures++; $display("FAIL wrap_frame%0d got=%h exp=%h", f, dut_vec, m_vec());
            end
            if (f == 161) begin
                checks++;
                if (carX_2 !== 10'd638) begin
                    failures++; $display("FAIL car2_wrap got=%0d exp=638", carX_2);
                end
            end
        end
        checks++;
        if (carX_1 !== 10'd638) begin
            failures++; $display("FAIL car1_at_638 got=%0d exp=638", carX_1);
        end
        do_frame(4'b0000);
        checks++;
        if (carX_1 !== 10'd0) begin
            failures++; $display("FAIL car1_wrap got=%0d exp=0", carX_1);
        end
    endtask

    task automatic test_goal_and_bounds();
        do_reset();
        do_start();
        for (int f = 1; f <= 93; f++) begin
            do_frame(f > 80 ? 4'b1000 : 4'b0000);
            checks++;
            if (dut_vec !== m_vec()) begin
                failures++; $display("FAIL goal_frame%0d got=%h exp=%h", f, dut_vec, m_vec());
            end
        end
        checks++;
        if ({score, raccoonX, raccoonY} !== {8'd1, 10'd288, 10'd416}) begin
            failures++;
            $display("FAIL goal_score got=%0d,%0d,%0d exp=1,288,416", score, raccoonX, raccoonY);
        end
        for (int i = 0; i < 10; i++) do_frame(4'b0010);
        checks++;
        if (raccoonX !== 10'd0) begin
            failures++; $display("FAIL left_edge got=%0d exp=0", raccoonX);
        end
        do_frame(4'b1001);
        checks++;
        if ({raccoonX, raccoonY} !== {10'd0, 10'd384}) begin
            failures++; $display("FAIL up_priority got=%0d,%0d exp=0,384", raccoonX, raccoonY);
        end
    endtask

    task automatic test_hit();
        do_reset();
        do_start();
        for (int f = 1; f <= 34; f++) do_frame(f > 30 ? 4'b1000 : 4'b0000);
        checks++;
        if ({lives, invuln, raccoonX, raccoonY} !== {3'd2, 1'b1, 10'd288, 10'd416}) begin
            failures++;
            $display("FAIL first_hit got=%0d,%0d,%0d,%0d exp=2,1,288,416",
                     lives, invuln, raccoonX, raccoonY);
        end
        for (int f = 35; f <= 93; f++) begin
            do_frame(f <= 38 ? 4'b1000 : 4'b0000);
            checks++;
            if (dut_vec !== m_vec()) begin
                failures++; $display("FAIL hit_frame%0d got=%h exp=%h", f, dut_vec, m_vec());
            end
        end
        checks++;
        if ({invuln, lives} !== {1'b1, 3'd2}) begin
            failures++; $display("FAIL hit_59 got=%0d,%0d exp=1,2", invuln, lives);
        end
        do_frame(4'b0000);
        checks++;
        if ({invuln, lives} !== {1'b0, 3'd2}) begin
            failures++; $display("FAIL hit_60 got=%0d,%0d exp=0,2", invuln, lives);
        end
    endtask

    task automatic test_reset_mid_hit();
        do_reset();
        do_start();
        for (int f = 1; f <= 36; f++) do_frame(f > 30 && f <= 34 ? 4'b1000 : 4'b0000);
        @(negedge clk) reset = 1'b1;
        @(negedge clk);
        checks++;
        if (dut_vec !== RESET_VEC) begin
            failures++; $display("FAIL reset_mid_hit got=%h exp=%h", dut_vec, RESET_VEC);
        end
        reset = 1'b0;
        m_reset();
    endtask

    task automatic test_over();
        logic [92:0] snap;
        int guard;
        do_reset();
        do_start();
        guard = 0;
        while (m_state != M_OVER && guard < 2000) begin
            do_frame(m_ry > 288 ? 4'b1000 : 4'b0000);
            guard++;
            checks++;
            if (dut_vec !== m_vec()) begin
                failures++; $display("FAIL over_frame%0d got=%h exp=%h", guard, dut_vec, m_vec());
            end
        end
        checks++;
        if ({lives, game_over} !== {3'd0, 1'b1}) begin
            failures++; $display("FAIL game_over got=%0d,%0d exp=0,1", lives, game_over);
        end
        snap = m_vec();
        for (int i = 0; i < 5; i++) begin
            do_frame(4'($urandom_range(0, 15)));
            checks++;
            if (dut_vec !== snap) begin
                failures++; $display("FAIL over_frozen got=%h exp=%h", dut_vec, snap);
            end
        end
        do_start();
        do_frame(4'b0000);
        checks++;
        if ({lives, score, game_over, invuln, carX_1, raccoonY} !==
            {3'd3, 8'd0, 1'b0, 1'b0, 10'd2, 10'd416}) begin
            failures++;
            $display("FAIL restart got=%0d,%0d,%0d,%0d,%0d,%0d exp=3,0,0,0,2,416",
                     lives, score, game_over, invuln, carX_1, raccoonY);
        end
    endtask

    task automatic test_random();
        do_reset();
        do_start();
        for (int f = 0; f < 300; f++) begin
            if ($urandom_range(0, 15) == 0) do_start();
            do_frame(4'($urandom_range(0, 15)));
            checks++;
            if (dut_vec !== m_vec()) begin
                failures++; $display("FAIL random_frame%0d got=%h exp=%h", f, dut_vec, m_vec());
            end
        end
    endtask

`ifdef PAUSE_EN
    task automatic test_pause();
        logic [92:0] snap;
        do_reset();
        do_start();
        do_frame(4'b0000);
        do_start();
        snap = m_vec();
        for (int i = 0; i < 10; i++) begin
            do_frame(4'($urandom_range(0, 15)));
            checks++;
            if (dut_vec !== snap) begin
                failures++; $display("FAIL paused_frozen got=%h exp=%h", dut_vec, snap);
            end
        end
        do_start();
        do_frame(4'b0000);
        checks++;
        if (carX_1 !== 10'd4 || dut_vec !== m_vec()) begin
            failures++; $display("FAIL pause_resume got=%h exp=%h", dut_vec, m_vec());
        end
    endtask
`endif

    initial begin
        m_reset();
        test_reset();
        test_start();
        test_wrap();
        test_goal_and_bounds();
        test_hit();
        test_reset_mid_hit();
        test_over();
        test_random();
`ifdef PAUSE_EN
        test_pause();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
